stream_decrypt_rx: RTL and testbench
====================================

Name: stream_decrypt_rx

Overview:
Receive-side counterpart of the team's LFSR stream-cipher encryptor. It accepts framed ciphertext on a valid/ready byte stream. The first byte of each frame is the clear-text seed; the remaining bytes are payload. Payload is decrypted with the identical 8-bit LFSR keystream and forwarded on a registered valid/ready output. It sits between the link deframer and the consumer, and reports framing errors.

Parameters:
SEED, 8'hCD, default LFSR state after reset; also substituted for a received seed of 0x00.
MAX_LEN, 1024, maximum payload bytes per frame (>=1).
CNT_W, 16, width of byte_cnt (must hold MAX_LEN).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext byte valid
in_ready  out  1  block accepts byte this cycle
in_data  in  8  seed byte or ciphertext byte
in_last  in  1  final byte of frame
out_valid  out  1  plaintext byte valid
out_ready  in  1  consumer accepts output
out_data  out  8  plaintext byte
out_last  out  1  final plaintext byte of frame
busy  out  1  high in PAYLOAD or DISCARD
frame_done  out  1  one-cycle pulse, frame completed normally
err_zero_seed  out  1  one-cycle pulse, seed 0x00 received
err_empty  out  1  one-cycle pulse, seed byte carried in_last
err_overlen  out  1  one-cycle pulse, MAX_LEN reached without in_last
byte_cnt  out  CNT_W  payload bytes accepted in current/last frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, lfsr=SEED, out_valid=0, out_data=0, out_last=0, byte_cnt=0, all pulses 0, busy=0. Reset mid-frame abandons the frame; no output is produced for it.
- LFSR step: fb = s[7]^s[5]^s[4]^s[3]; next = {s[6:0], fb}.
- Keystream alignment: payload byte i (i=0,1,...) is XORed with step^(i+1)(seed). This matches the encryptor, which advances its LFSR before the first XOR.
- Accept = in_valid & in_ready, evaluated on the rising clk edge.
- State IDLE:
  - in_ready=1.
  - On accept with in_last=0: lfsr <= step(seed'), byte_cnt <= 0, go to PAYLOAD. seed' = (in_data==0) ? SEED : in_data. err_zero_seed pulses if in_data==0.
  - On accept with in_last=1: err_empty pulses (err_zero_seed also pulses if the byte is 0), stay in IDLE, lfsr unchanged.
- State PAYLOAD:
  - in_ready = !out_valid | out_ready.
  - On accept: out_data <= in_data ^ lfsr, out_valid <= 1, lfsr <= step(lfsr), byte_cnt <= byte_cnt+1.
  - If in_last: out_last <= 1, frame_done pulses the following cycle, go to IDLE.
  - Else if byte_cnt+1 == MAX_LEN: out_last <= 1 (forced), err_overlen pulses, go to DISCARD.
  - in_last on the MAX_LEN-th byte is a normal end (frame_done, no error).
- State DISCARD:
  - in_ready=1. Bytes are dropped; no output, no LFSR or byte_cnt change.
  - Accept with in_last=1 goes to IDLE.
- Output register:
  - out_valid clears when out_ready=1 and no new accept occurs in the same cycle.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - A simultaneous drain and accept reloads the register with no bubble, giving 1 byte/clk sustained.
- Latency: one clock from accept to out_valid.
- A pending output from the previous frame may coexist with acceptance of the next seed in IDLE; the seed does not use the output register.
- byte_cnt holds after frame end until the next seed is accepted.
- Pulse outputs are registered and high for exactly one cycle.

Test Plan:
1. Reset, then seed 0xCD, then 0x8B, 0x17, 0x59 (last on 0x59), out_ready=1 -> out_data 0x11, 0x22, 0x33, each one cycle after accept. out_last only with 0x33; frame_done one pulse; byte_cnt=3.
2. Seed 0x00, then 0x9A, 0x35 (last) -> err_zero_seed pulse; out_data 0x00, 0x00 (SEED substituted).
3. Same stream as case 1 with out_ready=0 for 3 cycles after the first output -> in_ready=0 while stalled; out_data held at 0x11; no data loss or duplication; final sequence 0x11, 0x22, 0x33.
4. Seed byte with in_last=1 -> err_empty pulse; no out_valid; state stays IDLE; next frame per case 1 decrypts correctly.
5. MAX_LEN=2: seed 0xCD, then 0x8B, 0x17, 0xAA, 0xBB (last) -> outputs 0x11, 0x22 with out_last on 0x22; err_overlen pulse; 0xAA and 0xBB dropped; in_ready=1 throughout DISCARD; no frame_done.
6. Assert rst_n low after the second payload byte of case 1 -> out_valid=0 and byte_cnt=0 immediately; after release, a replay of case 1 yields 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/stream_decrypt_rx.sv
// ---------------------------------------------------------------------------
// stream_decrypt_rx
//   Receive side of the LFSR stream cipher. Each frame on the input stream
//   starts with a clear-text seed byte, followed by ciphertext payload bytes.
//   The payload is XORed with the 8-bit LFSR keystream and forwarded through a
//   registered valid/ready output stage. Framing problems are reported as
//   one-cycle pulses.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  ciphertext handshake; in_data seed or payload, in_last EOF
//   out_valid/ready plaintext handshake; out_data, out_last EOF
//   busy            high while in PAYLOAD or DISCARD
//   frame_done      pulse: frame ended normally
//   err_zero_seed   pulse: seed byte was 0x00 (SEED substituted)
//   err_empty       pulse: seed byte carried in_last
//   err_overlen     pulse: MAX_LEN payload bytes without in_last
//   byte_cnt        payload bytes accepted in current / last frame
// ---------------------------------------------------------------------------
module stream_decrypt_rx #(
    parameter logic [7:0]  SEED    = 8'hCD,
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done,
    output logic             err_zero_seed,
    output logic             err_empty,
    output logic             err_overlen,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DISCARD
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       lfsr;
    logic [7:0]       seed_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_max;
    logic             accept;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign accept   = in_valid & in_ready;
    assign seed_eff = (in_data == 8'h00) ? SEED : in_data;
    assign cnt_inc  = byte_cnt + CNT_W'(1);
    assign hit_max  = (cnt_inc == MAX_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (accept) begin
                    if (in_last)      state_nxt = IDLE;
                    else if (hit_max) state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (accept && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs. Only payload bytes need the output register,
    // so seed and discarded bytes are always accepted.
    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        case (state)
            PAYLOAD: begin
                in_ready = !out_valid || out_ready;
                busy     = 1'b1;
            end
            DISCARD: busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath: keystream, output register, byte counter, status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr          <= SEED;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            byte_cnt      <= '0;
            frame_done    <= 1'b0;
            err_zero_seed <= 1'b0;
            err_empty     <= 1'b0;
            err_overlen   <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            err_zero_seed <= 1'b0;
            err_empty     <= 1'b0;
            err_overlen   <= 1'b0;

            // Drain first; a payload accept below reloads in the same cycle.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        err_zero_seed <= (in_data == 8'h00);
                        if (in_last) begin
                            err_empty <= 1'b1;
                        end else begin
                            // Encryptor steps before its first XOR.
                            lfsr     <= lfsr_step(seed_eff);
                            byte_cnt <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        out_data    <= in_data ^ lfsr;
                        out_valid   <= 1'b1;
                        out_last    <= in_last | hit_max;
                        lfsr        <= lfsr_step(lfsr);
                        byte_cnt    <= cnt_inc;
                        frame_done  <= in_last;
                        err_overlen <= !in_last && hit_max;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_decrypt_rx.sv
// ---------------------------------------------------------------------------
// tb_stream_decrypt_rx
//   Self-checking bench for stream_decrypt_rx (MAX_LEN reduced to 4 so the
//   over-length path is reachable). Expected plaintext comes from a keystream
//   model built from the cipher rules; random frames are produced by
//   encrypting random plaintext with that model.
// ---------------------------------------------------------------------------
module tb_stream_decrypt_rx;

    localparam logic [7:0]  SEED    = 8'hCD;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic             frame_done;
    logic             err_zero_seed;
    logic             err_empty;
    logic             err_overlen;
    logic [CNT_W-1:0] byte_cnt;

    logic ready_man = 1'b1;
    logic bp_en     = 1'b0;
    logic bp_rand   = 1'b1;
    assign out_ready = bp_en ? bp_rand : ready_man;

    int errors = 0;
    int checks = 0;

    logic [8:0]  got[$];
    int unsigned n_done = 0, n_zero = 0, n_empty = 0, n_over = 0;

    stream_decrypt_rx #(
        .SEED    (SEED),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_zero_seed (err_zero_seed),
        .err_empty     (err_empty),
        .err_overlen   (err_overlen),
        .byte_cnt      (byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bp_rand = ($urandom_range(0, 3) != 0);
    end

    // Records every completed output transfer and pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            if (frame_done)    n_done++;
            if (err_zero_seed) n_zero++;
            if (err_empty)     n_empty++;
            if (err_overlen)   n_over++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ks_next(input logic [7:0] s);
        int unsigned v, fb;
        v  = s;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int unsigned waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                errors++;
                checks++;
                $display("FAIL send_timeout in_ready=%b required=1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_case1();
        send(8'hCD, 1'b0);
        send(8'h8B, 1'b0);
        send(8'h17, 1'b0);
        send(8'h59, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if ({out_valid, out_last, busy, frame_done, err_zero_seed, err_empty, err_overlen} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=0000000",
                {out_valid, out_last, busy, frame_done, err_zero_seed, err_empty, err_overlen});
        end
        checks++;
        if (out_data !== 8'h00 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data out_data=%h byte_cnt=%0d required 00/0", out_data, byte_cnt);
        end
        rst_n = 1'b1;
        idle(1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ct [3];
        logic [7:0] pt [3];
        int unsigned base, d0;
        ct = '{8'h8B, 8'h17, 8'h59};
        pt = '{8'h11, 8'h22, 8'h33};
        base = got.size();
        d0   = n_done;
        ready_man = 1'b1;
        send(8'hCD, 1'b0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_seed busy=%b out_valid=%b required 1/0", busy, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            send(ct[i], i == 2);
            checks++;
            if (out_valid !== 1'b1 || out_data !== pt[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_out%0d valid=%b data=%h last=%b required 1/%h/%b",
                    i, out_valid, out_data, out_last, pt[i], i == 2);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || byte_cnt !== 16'd3) begin
            errors++;
            $display("FAIL basic_done frame_done=%b byte_cnt=%0d required 1/3", frame_done, byte_cnt);
        end
        idle(1);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || byte_cnt !== 16'd3) begin
            errors++;
            $display("FAIL basic_after frame_done=%b busy=%b byte_cnt=%0d required 0/0/3",
                frame_done, busy, byte_cnt);
        end
        idle(2);
        checks++;
        if (got.size() - base != 3 || got[base] !== 9'h011 || got[base+1] !== 9'h022 ||
            got[base+2] !== 9'h133 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL basic_stream count=%0d done=%0d required 3 bytes 011,022,133 / 1 done",
                got.size() - base, n_done - d0);
        end
    endtask

    task automatic test_zero_seed();
        int unsigned z0;
        z0 = n_zero;
        send(8'h00, 1'b0);
        checks++;
        if (err_zero_seed !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse got=%b required=1", err_zero_seed);
        end
        send(8'h9A, 1'b0);
        checks++;
        if (out_data !== 8'h00 || err_zero_seed !== 1'b0) begin
            errors++;
            $display("FAIL zero_out0 data=%h pulse=%b required 00/0", out_data, err_zero_seed);
        end
        send(8'h35, 1'b1);
        checks++;
        if (out_data !== 8'h00 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL zero_out1 data=%h last=%b required 00/1", out_data, out_last);
        end
        idle(2);
        checks++;
        if (n_zero - z0 != 1) begin
            errors++;
            $display("FAIL zero_count got=%0d required=1", n_zero - z0);
        end
    endtask

    task automatic test_backpressure();
        int unsigned base;
        base = got.size();
        send(8'hCD, 1'b0);
        send(8'h8B, 1'b0);
        ready_man = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h17;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
                errors++;
                $display("FAIL stall%0d in_ready=%b valid=%b data=%h required 0/1/11",
                    i, in_ready, out_valid, out_data);
            end
        end
        @(posedge clk);
        #1;
        ready_man = 1'b1;
        send(8'h17, 1'b0);
        send(8'h59, 1'b1);
        idle(3);
        checks++;
        if (got.size() - base != 3 || got[base] !== 9'h011 || got[base+1] !== 9'h022 ||
            got[base+2] !== 9'h133) begin
            errors++;
            $display("FAIL stall_stream count=%0d required 3 bytes 011,022,133", got.size() - base);
        end
    endtask

    task automatic test_empty();
        int unsigned base, e0;
        e0 = n_empty;
        send(8'h5A, 1'b1);
        checks++;
        if (err_empty !== 1'b1 || err_zero_seed !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse empty=%b zero=%b valid=%b busy=%b required 1/0/0/0",
                err_empty, err_zero_seed, out_valid, busy);
        end
        send(8'h00, 1'b1);
        checks++;
        if (err_empty !== 1'b1 || err_zero_seed !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_zero empty=%b zero=%b busy=%b required 1/1/0",
                err_empty, err_zero_seed, busy);
        end
        base = got.size();
        send_case1();
        idle(3);
        checks++;
        if (got.size() - base != 3 || got[base] !== 9'h011 || got[base+1] !== 9'h022 ||
            got[base+2] !== 9'h133 || n_empty - e0 != 2) begin
            errors++;
            $display("FAIL empty_next count=%0d empties=%0d required 3 bytes / 2", got.size() - base,
                n_empty - e0);
        end
    endtask

    task automatic test_overlen();
        int unsigned base, o0, d0;
        logic [7:0] s, p;
        logic [8:0] exp_q[$];
        base = got.size();
        o0 = n_over;
        d0 = n_done;
        s = SEED;
        send(SEED, 1'b0);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            s = ks_next(s);
            p = 8'($urandom);
            exp_q.push_back({i == MAX_LEN - 1, p});
            send(p ^ s, 1'b0);
        end
        checks++;
        if (out_last !== 1'b1 || err_overlen !== 1'b1 || busy !== 1'b1 || byte_cnt !== 16'(MAX_LEN)) begin
            errors++;
            $display("FAIL overlen_hit last=%b pulse=%b busy=%b cnt=%0d required 1/1/1/%0d",
                out_last, err_overlen, busy, byte_cnt, MAX_LEN);
        end
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom), i == 2);
            checks++;
            if (in_ready !== 1'b1 || busy !== (i != 2) || byte_cnt !== 16'(MAX_LEN)) begin
                errors++;
                $display("FAIL discard%0d in_ready=%b busy=%b cnt=%0d required 1/%b/%0d",
                    i, in_ready, busy, byte_cnt, i != 2, MAX_LEN);
            end
        end
        idle(3);
        checks++;
        if (got.size() - base != MAX_LEN || n_over - o0 != 1 || n_done - d0 != 0) begin
            errors++;
            $display("FAIL overlen_counts bytes=%0d over=%0d done=%0d required %0d/1/0",
                got.size() - base, n_over - o0, n_done - d0, MAX_LEN);
        end
        for (int unsigned i = 0; i < MAX_LEN && base + i < got.size(); i++) begin
            checks++;
            if (got[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overlen_byte%0d got=%h required=%h", i, got[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_boundary();
        int unsigned base, o0, d0;
        logic [7:0] s, p, sd;
        logic [8:0] exp_q[$];
        base = got.size();
        o0 = n_over;
        d0 = n_done;
        sd = 8'($urandom_range(1, 255));
        s = sd;
        send(sd, 1'b0);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            s = ks_next(s);
            p = 8'($urandom);
            exp_q.push_back({i == MAX_LEN - 1, p});
            send(p ^ s, i == MAX_LEN - 1);
        end
        checks++;
        if (frame_done !== 1'b1 || err_overlen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL boundary_end done=%b over=%b busy=%b required 1/0/0",
                frame_done, err_overlen, busy);
        end
        idle(3);
        checks++;
        if (got.size() - base != MAX_LEN || n_over != o0 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL boundary_counts bytes=%0d over=%0d done=%0d required %0d/0/1",
                got.size() - base, n_over - o0, n_done - d0, MAX_LEN);
        end
        for (int unsigned i = 0; i < MAX_LEN && base + i < got.size(); i++) begin
            checks++;
            if (got[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL boundary_byte%0d got=%h required=%h", i, got[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int unsigned base, d0, z0, zeros, len;
        logic [7:0] s, p, sd;
        logic [8:0] exp_q[$];
        base = got.size();
        d0 = n_done;
        z0 = n_zero;
        zeros = 0;
        bp_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, MAX_LEN);
            sd  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if (sd == 8'h00) zeros++;
            s = (sd == 8'h00) ? SEED : sd;
            idle($urandom_range(0, 2));
            send(sd, 1'b0);
            for (int unsigned i = 0; i < len; i++) begin
                s = ks_next(s);
                p = 8'($urandom);
                exp_q.push_back({i == len - 1, p});
                if ($urandom_range(0, 3) == 0) idle(1);
                send(p ^ s, i == len - 1);
            end
            checks++;
            if (byte_cnt !== 16'(len)) begin
                errors++;
                $display("FAIL rand_cnt frame=%0d got=%0d required=%0d", f, byte_cnt, len);
            end
        end
        bp_en = 1'b0;
        ready_man = 1'b1;
        idle(5);
        checks++;
        if (got.size() - base != exp_q.size() || n_done - d0 != 20 || n_zero - z0 != zeros) begin
            errors++;
            $display("FAIL rand_counts bytes=%0d done=%0d zero=%0d required %0d/20/%0d",
                got.size() - base, n_done - d0, n_zero - z0, exp_q.size(), zeros);
        end
        for (int unsigned i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            checks++;
            if (got[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got=%h required=%h", i, got[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned base;
        base = got.size();
        send(8'hCD, 1'b0);
        send(8'h8B, 1'b0);
        send(8'h17, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || byte_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset valid=%b cnt=%0d busy=%b required 0/0/0", out_valid, byte_cnt, busy);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_case1();
        idle(3);
        checks++;
        if (got.size() - base != 4 || got[base] !== 9'h011 || got[base+1] !== 9'h011 ||
            got[base+2] !== 9'h022 || got[base+3] !== 9'h133) begin
            errors++;
            $display("FAIL midreset_stream count=%0d required 4 bytes 011,011,022,133", got.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_seed();
        test_backpressure();
        test_empty();
        test_overlen();
        test_boundary();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
